// File: rtl/bfly_node_arb.sv
// bfly_node_arb: registered 2x2 butterfly node with round-robin arbitration per output; optional BFLY_ARB_CNT_EN adds conflict counters.
// Latency: 1 cycle from accept edge to o_data/o_valid; full throughput per output.
// Backpressure: i_ready is combinational; the loser and any input blocked by a held slot stall, with no loss.
module bfly_node_arb #(
   parameter int DW      = 35,
   parameter int DIR_BIT = DW-1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] i_data0,
   input  logic [DW-1:0] i_data1,
   input  logic          i_valid0,
   input  logic          i_valid1,
   output logic          i_ready0,
   output logic          i_ready1,
   output logic [DW-1:0] o_data0,
   output logic [DW-1:0] o_data1,
   output logic          o_valid0,
   output logic          o_valid1,
   input  logic          o_ready0,
   input  logic          o_ready1
`ifdef BFLY_ARB_CNT_EN
   ,
   output logic [15:0]   conflict_cnt0,
   output logic [15:0]   conflict_cnt1
`endif
);

   // Bit vectors below are indexed by output port.
   logic [1:0]    req_in0, req_in1;
   logic [1:0]    slot_free, contend;
   logic [1:0]    gnt_in0, gnt_in1;
   logic [1:0]    prio_q;
   logic [1:0]    vld_q;
   logic [DW-1:0] dat_q [2];

   always_comb begin
      req_in0   = {i_valid0 &  i_data0[DIR_BIT], i_valid0 & ~i_data0[DIR_BIT]};
      req_in1   = {i_valid1 &  i_data1[DIR_BIT], i_valid1 & ~i_data1[DIR_BIT]};
      slot_free = ~vld_q | {o_ready1, o_ready0};
      contend   = req_in0 & req_in1 & slot_free;
      gnt_in0   = slot_free & req_in0 & (~req_in1 | ~prio_q);
      gnt_in1   = slot_free & req_in1 & (~req_in0 |  prio_q);
   end

   assign i_ready0 = ~rst & (|gnt_in0);
   assign i_ready1 = ~rst & (|gnt_in1);
   assign o_valid0 = vld_q[0];
   assign o_valid1 = vld_q[1];
   assign o_data0  = dat_q[0];
   assign o_data1  = dat_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         prio_q <= '0;
         for (int k = 0; k < 2; k++) dat_q[k] <= '0;
      end else begin
         // Priority flips only when a real contest was resolved.
         prio_q <= prio_q ^ contend;
         for (int k = 0; k < 2; k++) begin
            if (gnt_in0[k]) begin
               vld_q[k] <= 1'b1;
               dat_q[k] <= i_data0;
            end else if (gnt_in1[k]) begin
               vld_q[k] <= 1'b1;
               dat_q[k] <= i_data1;
            end else if (slot_free[k]) begin
               vld_q[k] <= 1'b0;
            end
         end
      end
   end

`ifdef BFLY_ARB_CNT_EN
   logic [15:0] cnt_q [2];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < 2; k++)
            if (contend[k] && cnt_q[k] != 16'hFFFF) cnt_q[k] <= cnt_q[k] + 16'd1;
      end
   end

   assign conflict_cnt0 = cnt_q[0];
   assign conflict_cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_bfly_node_arb.sv
// Randomized + directed bench for bfly_node_arb against a rule-level reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_bfly_node_arb;
   localparam int DW      = 35;
   localparam int DIR_BIT = DW-1;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] i_data0, i_data1;
   logic          i_valid0, i_valid1;
   logic          i_ready0, i_ready1;
   logic [DW-1:0] o_data0, o_data1;
   logic          o_valid0, o_valid1;
   logic          o_ready0, o_ready1;
`ifdef BFLY_ARB_CNT_EN
   logic [15:0]   conflict_cnt0, conflict_cnt1;
`endif

   bfly_node_arb #(.DW(DW), .DIR_BIT(DIR_BIT)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_data0  (i_data0),
      .i_data1  (i_data1),
      .i_valid0 (i_valid0),
      .i_valid1 (i_valid1),
      .i_ready0 (i_ready0),
      .i_ready1 (i_ready1),
      .o_data0  (o_data0),
      .o_data1  (o_data1),
      .o_valid0 (o_valid0),
      .o_valid1 (o_valid1),
      .o_ready0 (o_ready0),
      .o_ready1 (o_ready1)
`ifdef BFLY_ARB_CNT_EN
      ,
      .conflict_cnt0 (conflict_cnt0),
      .conflict_cnt1 (conflict_cnt1)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: content of each output slot, arbitration turn, conflict tally.
   logic          mv   [2];
   logic [DW-1:0] md   [2];
   logic          mp   [2];
   int            mcnt [2];

   // Per-step results: which inputs the model accepted, and observed readies.
   logic acc0, acc1;
   logic rdy_obs0, rdy_obs1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mv[k] = 1'b0; md[k] = '0; mp[k] = 1'b0; mcnt[k] = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_ov0"}, 64'(o_valid0), 64'(mv[0]));
      check_eq({tag, "_ov1"}, 64'(o_valid1), 64'(mv[1]));
      check_eq({tag, "_od0"}, 64'(o_data0),  64'(md[0]));
      check_eq({tag, "_od1"}, 64'(o_data1),  64'(md[1]));
`ifdef BFLY_ARB_CNT_EN
      check_eq({tag, "_cc0"}, 64'(conflict_cnt0), 64'(mcnt[0]));
      check_eq({tag, "_cc1"}, 64'(conflict_cnt1), 64'(mcnt[1]));
`endif
   endtask

   // One clock of traffic: drive, predict grants, compare readies, clock, compare outputs.
   task automatic step(input logic [DW-1:0] d0, input logic v0,
                       input logic [DW-1:0] d1, input logic v1,
                       input logic r0, input logic r1, input string tag);
      logic [DW-1:0] din [2];
      logic          vin [2];
      logic          rin [2];
      int            winner;
      int            nreq;
      @(negedge clk);
      i_data0 = d0; i_valid0 = v0; i_data1 = d1; i_valid1 = v1;
      o_ready0 = r0; o_ready1 = r1;
      #1;
      din[0] = d0; din[1] = d1; vin[0] = v0; vin[1] = v1; rin[0] = r0; rin[1] = r1;
      acc0 = 1'b0; acc1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         nreq   = 0;
         winner = -1;
         for (int j = 0; j < 2; j++)
            if (vin[j] && din[j][DIR_BIT] == k[0]) begin
               nreq++;
               winner = j;
            end
         if (!mv[k] || rin[k]) begin
            if (nreq == 2) begin
               winner = int'(mp[k]);
               mp[k]  = ~mp[k];
               if (mcnt[k] < 65535) mcnt[k]++;
            end
            if (nreq > 0) begin
               mv[k] = 1'b1;
               md[k] = din[winner];
               if (winner == 0) acc0 = 1'b1; else acc1 = 1'b1;
            end else begin
               mv[k] = 1'b0;
            end
         end
      end
      rdy_obs0 = i_ready0;
      rdy_obs1 = i_ready1;
      check_eq({tag, "_rdy0"}, 64'(rdy_obs0), 64'(acc0));
      check_eq({tag, "_rdy1"}, 64'(rdy_obs1), 64'(acc1));
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      i_valid0 = 1'b1; i_valid1 = 1'b1; o_ready0 = 1'b1; o_ready1 = 1'b1;
      i_data0 = 35'h0_12345678; i_data1 = 35'h4_87654321;
      #1;
      check_eq({tag, "_rst_rdy0"}, 64'(i_ready0), 64'd0);
      check_eq({tag, "_rst_rdy1"}, 64'(i_ready1), 64'd0);
      @(posedge clk);
      #1;
      model_reset();
      check_outputs({tag, "_rst"});
      @(negedge clk);
      rst = 1'b0;
      i_valid0 = 1'b0; i_valid1 = 1'b0;
   endtask

   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   int            order [$];
   logic [DW-1:0] pa, pb, rd0, rd1;
   logic          rv0, rv1, held0, held1;
   int            cyc;

   initial begin
      rst = 1'b1;
      i_data0 = '0; i_data1 = '0; i_valid0 = 1'b0; i_valid1 = 1'b0;
      o_ready0 = 1'b0; o_ready1 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("init");
      @(negedge clk);
      rst = 1'b0;

      // Straight routing
      step(35'h0_DEADBEEF, 1'b1, 35'h4_CAFEF00D, 1'b1, 1'b1, 1'b1, "straight");
      check_eq("straight_acc0", 64'(rdy_obs0), 64'd1);
      check_eq("straight_acc1", 64'(rdy_obs1), 64'd1);
      check_eq("straight_o0", 64'(o_data0), 64'h0_DEADBEEF);
      check_eq("straight_o1", 64'(o_data1), 64'h4_CAFEF00D);

      // Cross routing
      step(35'h4_11111111, 1'b1, 35'h0_22222222, 1'b1, 1'b1, 1'b1, "cross");
      check_eq("cross_o1", 64'(o_data1), 64'h4_11111111);
      check_eq("cross_o0", 64'(o_data0), 64'h0_22222222);
      check_eq("cross_v",  64'({o_valid1, o_valid0}), 64'd3);

      // Reset while both outputs hold packets
      do_reset("midrst");

      // Contention fairness: 4 packets per input, all to output 0
      for (int i = 0; i < 4; i++) begin
         q0.push_back(35'h0_A0000000 + 35'(i));
         q1.push_back(35'h0_B0000000 + 35'(i));
      end
      cyc = 0;
      while ((q0.size() > 0 || q1.size() > 0) && cyc < 20) begin
         step(q0.size() > 0 ? q0[0] : '0, q0.size() > 0,
              q1.size() > 0 ? q1[0] : '0, q1.size() > 0, 1'b1, 1'b1, "fair");
         if (acc0) begin void'(q0.pop_front()); order.push_back(0); end
         if (acc1) begin void'(q1.pop_front()); order.push_back(1); end
         cyc++;
`ifdef BFLY_ARB_CNT_EN
         if (cyc == 4) check_eq("fair_cnt4", 64'(conflict_cnt0), 64'd4);
`endif
      end
      check_eq("fair_cycles", 64'(cyc), 64'd8);
      check_eq("fair_count", 64'(order.size()), 64'd8);
      for (int i = 0; i < order.size() && i < 8; i++)
         check_eq($sformatf("fair_order%0d", i), 64'(order[i]), 64'(i % 2));
`ifdef BFLY_ARB_CNT_EN
      check_eq("fair_cnt_end", 64'(conflict_cnt0), 64'd7);
`endif

      // Backpressure on output 0, both inputs waiting
      do_reset("bp");
      pa = 35'h0_AAAA5555;
      pb = 35'h0_BBBB0000;
      step(pa, 1'b1, '0, 1'b0, 1'b1, 1'b1, "bp_fill");
      for (int i = 0; i < 5; i++) begin
         step(pb, 1'b1, pb + 35'd1, 1'b1, 1'b0, 1'b1, "bp_hold");
         check_eq("bp_stable", 64'(o_data0), 64'(pa));
         check_eq("bp_noacc", 64'(rdy_obs0), 64'd0);
      end
`ifdef BFLY_ARB_CNT_EN
      check_eq("bp_cnt", 64'(conflict_cnt0), 64'd0);
`endif
      step(pb, 1'b1, pb + 35'd1, 1'b1, 1'b1, 1'b1, "bp_release");
      check_eq("bp_rel_rdy0", 64'(rdy_obs0), 64'd1);
      check_eq("bp_rel_od0", 64'(o_data0), 64'(pb));
      check_eq("bp_rel_ov0", 64'(o_valid0), 64'd1);

      // Random traffic honouring the hold-while-stalled contract
      held0 = 1'b0; held1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!held0) begin
            rv0 = ($urandom_range(0, 3) != 0);
            rd0 = {3'($urandom_range(0, 7)), 32'($urandom)};
         end
         if (!held1) begin
            rv1 = ($urandom_range(0, 3) != 0);
            rd1 = {3'($urandom_range(0, 7)), 32'($urandom)};
         end
         step(rd0, rv0, rd1, rv1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, "rand");
         held0 = rv0 && !acc0;
         held1 = rv1 && !acc1;
      end

`ifdef BFLY_ARB_CNT_EN
      // Saturation of the output-1 conflict counter
      do_reset("sat");
      for (int i = 0; i < 65540; i++)
         step(35'h4_00000001, 1'b1, 35'h4_00000002, 1'b1, 1'b1, 1'b1, "sat");
      check_eq("sat_cnt1", 64'(conflict_cnt1), 64'hFFFF);
      step(35'h4_00000001, 1'b1, 35'h4_00000002, 1'b1, 1'b1, 1'b1, "sat_hold");
      check_eq("sat_cnt1_held", 64'(conflict_cnt1), 64'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
